// File: rtl/width_trans_pkg.sv
// Shared constants and elaboration-time helpers for the width-translating FIFO.
// Pure compile-time content; no latency or handshake of its own.
// Not applicable: the package carries no datapath.
package width_trans_pkg;

    localparam int LSB_FIRST = 0;
    localparam int MSB_FIRST = 1;

    function automatic int min_w(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Number of U-bit units in a word of width w.
    function automatic int ratio(input int w, input int u);
        return w / u;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/width_trans_regfile.sv
// Flop array of DEPTH x U bits with a WU-unit write port and an RU-unit read port at wrapping base addresses.
// Write takes effect on the clock edge; read is combinational from the array.
// No handshake: the caller decides when to write, and reads are always available.
module width_trans_regfile #(
    parameter int U         = 8,
    parameter int ADDR_SIZE = 4,
    parameter int WU        = 4,
    parameter int RU        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [WU*U-1:0]      wdata,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [RU*U-1:0]      rdata
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [U-1:0] mem [DEPTH];

    // Unit addresses are computed in ADDR_SIZE bits so a straddling access wraps per unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int k = 0; k < WU; k++) mem[waddr + ADDR_SIZE'(k)] <= wdata[k*U +: U];
        end
    end

    for (genvar k = 0; k < RU; k++) begin : g_rd
        assign rdata[k*U +: U] = mem[raddr + ADDR_SIZE'(k)];
    end

endmodule

// File: rtl/width_trans_fifo.sv
// Single-clock FIFO converting WRDATA_SIZE-bit writes into RDDATA_SIZE-bit reads, with selectable chunk order.
// Data written at one edge is readable from the next edge once a full read word is present; rd_data is show-ahead.
// wr_ready/rd_valid come from the registered level only; flush and rst override any same-cycle fire.
module width_trans_fifo
    import width_trans_pkg::*;
#(
    parameter int WRDATA_SIZE = 32,
    parameter int RDDATA_SIZE = 8,
    parameter int ADDR_SIZE   = 4,
    parameter int BIG_ENDIAN  = LSB_FIRST
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [WRDATA_SIZE-1:0] wr_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [RDDATA_SIZE-1:0] rd_data,
    output logic [ADDR_SIZE:0]     level
);

    localparam int U     = min_w(WRDATA_SIZE, RDDATA_SIZE);
    localparam int WU    = ratio(WRDATA_SIZE, U);
    localparam int RU    = ratio(RDDATA_SIZE, U);
    localparam int DEPTH = 1 << ADDR_SIZE;

    localparam logic [ADDR_SIZE:0] WU_L    = (ADDR_SIZE+1)'(WU);
    localparam logic [ADDR_SIZE:0] RU_L    = (ADDR_SIZE+1)'(RU);
    localparam logic [ADDR_SIZE:0] SPACE_L = (ADDR_SIZE+1)'(DEPTH - WU);

    if (max_w(WRDATA_SIZE, RDDATA_SIZE) % U != 0) begin : g_bad_ratio
        $error("width_trans_fifo: larger width must be a multiple of the smaller");
    end
    if (ADDR_SIZE < clog2(max_w(WU, RU))) begin : g_bad_depth
        $error("width_trans_fifo: storage too shallow for one full word");
    end

    logic [ADDR_SIZE-1:0] wptr;
    logic [ADDR_SIZE-1:0] rptr;
    logic                 wfire;
    logic                 rfire;
    logic [WU*U-1:0]      wunits;
    logic [RU*U-1:0]      runits;

    assign wr_ready = (level <= SPACE_L);
    assign rd_valid = (level >= RU_L);
    assign wfire    = wr_valid && wr_ready;
    assign rfire    = rd_valid && rd_ready;

    // Storage is kept in address order; chunk order is applied only at the ports.
    for (genvar k = 0; k < WU; k++) begin : g_wr_order
        assign wunits[k*U +: U] = (BIG_ENDIAN == MSB_FIRST) ? wr_data[(WU-1-k)*U +: U]
                                                            : wr_data[k*U +: U];
    end
    for (genvar k = 0; k < RU; k++) begin : g_rd_order
        assign rd_data[k*U +: U] = (BIG_ENDIAN == MSB_FIRST) ? runits[(RU-1-k)*U +: U]
                                                             : runits[k*U +: U];
    end

    width_trans_regfile #(
        .U         (U),
        .ADDR_SIZE (ADDR_SIZE),
        .WU        (WU),
        .RU        (RU)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (wfire && !flush),
        .waddr (wptr),
        .wdata (wunits),
        .raddr (rptr),
        .rdata (runits)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wfire) wptr <= wptr + ADDR_SIZE'(WU);
            if (rfire) rptr <= rptr + ADDR_SIZE'(RU);
            level <= level + (wfire ? WU_L : '0) - (rfire ? RU_L : '0);
        end
    end

endmodule

// File: tb/tb_width_trans_fifo.sv
// Directed bench for width_trans_fifo: 32->8 (both orders), 8->32 and 24->8 (wrapping writes).
module tb_width_trans_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, zero;
    int   tests = 0;
    int   failed = 0;

    // A: 32->8 little-endian, scoreboard-checked
    logic a_flush, a_wv, a_wr, a_rv, a_rr;
    logic [31:0] a_wd;
    logic [7:0]  a_rd;
    logic [4:0]  a_lvl;
    // B: 32->8 big-endian
    logic b_wv, b_wr, b_rv, b_rr;
    logic [31:0] b_wd;
    logic [7:0]  b_rd;
    logic [4:0]  b_lvl;
    // C: 8->32 little-endian
    logic c_wv, c_wr, c_rv, c_rr;
    logic [7:0]  c_wd;
    logic [31:0] c_rd;
    logic [4:0]  c_lvl;
    // D: 24->8 little-endian, writes straddle the top of storage
    logic d_wv, d_wr, d_rv, d_rr;
    logic [23:0] d_wd;
    logic [7:0]  d_rd;
    logic [4:0]  d_lvl;

    logic [7:0] qa[$];
    logic [7:0] qd[$];
    int lvl_a, lvl_d;

    width_trans_fifo #(.WRDATA_SIZE(32), .RDDATA_SIZE(8), .ADDR_SIZE(4), .BIG_ENDIAN(0)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .wr_valid(a_wv), .wr_ready(a_wr), .wr_data(a_wd),
        .rd_valid(a_rv), .rd_ready(a_rr), .rd_data(a_rd), .level(a_lvl));
    width_trans_fifo #(.WRDATA_SIZE(32), .RDDATA_SIZE(8), .ADDR_SIZE(4), .BIG_ENDIAN(1)) dut_b (
        .clk(clk), .rst(rst), .flush(zero), .wr_valid(b_wv), .wr_ready(b_wr), .wr_data(b_wd),
        .rd_valid(b_rv), .rd_ready(b_rr), .rd_data(b_rd), .level(b_lvl));
    width_trans_fifo #(.WRDATA_SIZE(8), .RDDATA_SIZE(32), .ADDR_SIZE(4), .BIG_ENDIAN(0)) dut_c (
        .clk(clk), .rst(rst), .flush(zero), .wr_valid(c_wv), .wr_ready(c_wr), .wr_data(c_wd),
        .rd_valid(c_rv), .rd_ready(c_rr), .rd_data(c_rd), .level(c_lvl));
    width_trans_fifo #(.WRDATA_SIZE(24), .RDDATA_SIZE(8), .ADDR_SIZE(4), .BIG_ENDIAN(0)) dut_d (
        .clk(clk), .rst(rst), .flush(zero), .wr_valid(d_wv), .wr_ready(d_wr), .wr_data(d_wd),
        .rd_valid(d_rv), .rd_ready(d_rr), .rd_data(d_rd), .level(d_lvl));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on A: check flags against the model, pop/compare on read fire, push on write fire.
    task automatic cyc_a();
        logic ew, ev;
        ew = ((16 - lvl_a) >= 4);
        ev = (lvl_a >= 1);
        chk("a_wr_ready", a_wr, ew);
        chk("a_rd_valid", a_rv, ev);
        if (ev && a_rr) begin
            if (qa.size() == 0) begin
                tests++; failed++;
                $error("FAIL a_sb_underflow: observed %h expected none", a_rd);
            end else begin
                chk("a_rd_data", a_rd, qa.pop_front());
            end
            lvl_a -= 1;
        end
        if (a_wv && ew) begin
            for (int k = 0; k < 4; k++) qa.push_back(a_wd[k*8 +: 8]);
            lvl_a += 4;
        end
        tick();
        chk("a_level", a_lvl, lvl_a);
    endtask

    task automatic cyc_d();
        logic ew, ev;
        ew = ((16 - lvl_d) >= 3);
        ev = (lvl_d >= 1);
        chk("d_wr_ready", d_wr, ew);
        chk("d_rd_valid", d_rv, ev);
        if (ev && d_rr) begin
            if (qd.size() == 0) begin
                tests++; failed++;
                $error("FAIL d_sb_underflow: observed %h expected none", d_rd);
            end else begin
                chk("d_rd_data", d_rd, qd.pop_front());
            end
            lvl_d -= 1;
        end
        if (d_wv && ew) begin
            for (int k = 0; k < 3; k++) qd.push_back(d_wd[k*8 +: 8]);
            lvl_d += 3;
        end
        tick();
        chk("d_level", d_lvl, lvl_d);
    endtask

    task automatic fill_a_to_six();
        a_rr = 1'b0; a_wv = 1'b1;
        a_wd = 32'h7B7A7978; cyc_a();
        a_wd = 32'h7F7E7D7C; cyc_a();
        a_wv = 1'b0; a_rr = 1'b1;
        cyc_a(); cyc_a();
        a_rr = 1'b0;
        chk("a_level_six", a_lvl, 6);
    endtask

    logic [7:0] be_exp [4];

    initial begin
        rst = 1'b1; zero = 1'b0; a_flush = 1'b0;
        a_wv = 0; a_rr = 0; a_wd = '0;
        b_wv = 0; b_rr = 0; b_wd = '0;
        c_wv = 0; c_rr = 0; c_wd = '0;
        d_wv = 0; d_rr = 0; d_wd = '0;
        lvl_a = 0; lvl_d = 0;
        tick(); tick();
        chk("rst_wr_ready", a_wr, 1);
        chk("rst_rd_valid", a_rv, 0);
        chk("rst_rd_data", a_rd, 0);
        chk("rst_level", a_lvl, 0);
        chk("rst_c_rd_data", c_rd, 0);
        chk("rst_b_wr_ready", b_wr, 1);
        rst = 1'b0;

        // Single word, consumer always ready
        a_wd = 32'hDDCCBBAA; a_wv = 1'b1; a_rr = 1'b1;
        cyc_a();
        a_wv = 1'b0;
        repeat (5) cyc_a();

        // Fill to full, overflow attempt, drain
        a_rr = 1'b0; a_wv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_wd = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            cyc_a();
        end
        chk("a_full_level", a_lvl, 16);
        chk("a_full_wr_ready", a_wr, 0);
        a_wd = 32'h11111111;
        cyc_a();
        a_wv = 1'b0; a_rr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc_a();
            if (i == 2) chk("a_wr_ready_after3", a_wr, 0);
            if (i == 3) chk("a_wr_ready_after4", a_wr, 1);
        end
        cyc_a();

        // Simultaneous write and read at level 4
        a_rr = 1'b0; a_wv = 1'b1; a_wd = 32'h44332211;
        cyc_a();
        a_rr = 1'b1; a_wd = 32'h88776655;
        cyc_a();
        chk("a_simul_level", a_lvl, 7);
        a_wv = 1'b0;
        repeat (8) cyc_a();

        // Flush overrides a concurrent write and read
        fill_a_to_six();
        a_flush = 1'b1; a_wv = 1'b1; a_rr = 1'b1; a_wd = 32'hDEADBEEF;
        tick();
        a_flush = 1'b0; a_wv = 1'b0; a_rr = 1'b0;
        qa.delete(); lvl_a = 0;
        chk("flush_level", a_lvl, 0);
        chk("flush_rd_valid", a_rv, 0);
        cyc_a();
        a_wv = 1'b1; a_wd = 32'h0D0C0B0A;
        cyc_a();
        a_wv = 1'b0; a_rr = 1'b1;
        repeat (5) cyc_a();
        a_rr = 1'b0;

        // Big-endian chunk order
        be_exp[0] = 8'hDD; be_exp[1] = 8'hCC; be_exp[2] = 8'hBB; be_exp[3] = 8'hAA;
        b_wd = 32'hDDCCBBAA; b_wv = 1'b1;
        tick();
        b_wv = 1'b0; b_rr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("b_rd_valid", b_rv, 1);
            chk("b_rd_data", b_rd, be_exp[i]);
            tick();
        end
        b_rr = 1'b0;
        chk("b_empty_valid", b_rv, 0);
        chk("b_empty_level", b_lvl, 0);

        // Narrow-to-wide packing
        c_wv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_wd = 8'(i + 1);
            chk("c_rd_valid_early", c_rv, 0);
            chk("c_wr_ready", c_wr, 1);
            tick();
        end
        c_wv = 1'b0;
        chk("c_rd_valid", c_rv, 1);
        chk("c_rd_data", c_rd, 32'h04030201);
        chk("c_level", c_lvl, 4);
        c_rr = 1'b1;
        tick();
        c_rr = 1'b0;
        chk("c_pop_level", c_lvl, 0);
        chk("c_pop_valid", c_rv, 0);

        // 24->8: advance pointers to 15, then a write straddling 15 -> 0 -> 1
        d_rr = 1'b1; d_wv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_wd = 24'(32'h010203 * (i + 1));
            cyc_d();
        end
        d_wv = 1'b0;
        for (int i = 0; i < 32 && lvl_d != 0; i++) cyc_d();
        chk("d_drained", d_lvl, 0);
        d_rr = 1'b0; d_wv = 1'b1; d_wd = 24'h332211;
        cyc_d();
        d_wv = 1'b0; d_rr = 1'b1;
        repeat (4) cyc_d();

        // Reset mid-operation beats a concurrent write and clears storage
        fill_a_to_six();
        rst = 1'b1; a_wv = 1'b1; a_wd = 32'hCAFEF00D;
        tick();
        rst = 1'b0; a_wv = 1'b0;
        chk("rst_mid_level", a_lvl, 0);
        chk("rst_mid_rd_valid", a_rv, 0);
        chk("rst_mid_rd_data", a_rd, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
